// File: rtl/xmit_arbiter.sv
// xmit_arbiter: shares the SPI transmitter byte port among ID, meta and sample requesters.
// Optional macro XMIT_ARB_ROUNDROBIN_EN: meta and sample alternate on ties; id keeps priority.
//
// state | meaning
// IDLE  | no word in progress; wait for a pending source and tx_busy=0
// GRANT | granted source fixed, byte mask loaded
// SEND  | tx_write strobe for the lowest remaining mask byte
// GUARD | tx_busy ignored while the transmitter raises it
// WAIT  | wait for tx_busy to drop before next byte or completion
// DONE  | *_done pulse for the granted source
module xmit_arbiter #(
  parameter logic [31:0] ID_WORD      = 32'h534C4131,
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic        id_req,
  input  logic        meta_req,
  input  logic [7:0]  meta_data,
  input  logic        sample_req,
  input  logic [31:0] sample_data,
  input  logic [3:0]  disabled_groups,
  input  logic        tx_busy,
  output logic        tx_write,
  output logic [7:0]  tx_byte,
  output logic        id_done,
  output logic        meta_done,
  output logic        sample_done,
  output logic        xmit_idle,
  output logic        overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_SEND, S_GUARD, S_WAIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SRC_ID, SRC_META, SRC_SAMPLE
  } src_t;

  localparam logic [1:0] GUARD_LOAD = 2'(GUARD_CYCLES - 1);

  state_t      state_q, state_d;
  src_t        src_q, pick_src;
  logic [3:0]  mask_q, mask_sel, mask_cur, low_bit;
  logic [31:0] word_sel;
  logic [7:0]  byte_pick, tx_byte_q;
  logic [1:0]  guard_cnt_q;
  logic        load_byte;
  logic        id_pend_q, meta_pend_q, sample_pend_q, any_pend;
  logic [7:0]  meta_data_q;
  logic [31:0] sample_data_q;
  logic [3:0]  sample_mask_q;
  logic        overflow_q, overflow_hit;

`ifdef XMIT_ARB_ROUNDROBIN_EN
  logic        last_meta_q;
`endif

  assign any_pend = id_pend_q | meta_pend_q | sample_pend_q;

  always_comb begin
    pick_src = SRC_SAMPLE;
    if (id_pend_q) begin
      pick_src = SRC_ID;
    end else if (meta_pend_q && sample_pend_q) begin
`ifdef XMIT_ARB_ROUNDROBIN_EN
      pick_src = last_meta_q ? SRC_SAMPLE : SRC_META;
`else
      pick_src = SRC_META;
`endif
    end else if (meta_pend_q) begin
      pick_src = SRC_META;
    end
  end

  always_comb begin
    word_sel = ID_WORD;
    mask_sel = 4'b1111;
    unique case (src_q)
      SRC_ID: begin
        word_sel = ID_WORD;
        mask_sel = 4'b1111;
      end
      SRC_META: begin
        word_sel = {24'h000000, meta_data_q};
        mask_sel = 4'b0001;
      end
      SRC_SAMPLE: begin
        word_sel = sample_data_q;
        mask_sel = sample_mask_q;
      end
      default: begin
        word_sel = ID_WORD;
        mask_sel = 4'b0000;
      end
    endcase
  end

  // GRANT works from the freshly selected mask; later bytes from the remaining mask
  assign mask_cur = (state_q == S_GRANT) ? mask_sel : mask_q;
  assign low_bit  = mask_cur & (~mask_cur + 4'd1);

  always_comb begin
    byte_pick = word_sel[7:0];
    if (low_bit[1]) byte_pick = word_sel[15:8];
    if (low_bit[2]) byte_pick = word_sel[23:16];
    if (low_bit[3]) byte_pick = word_sel[31:24];
  end

  always_comb begin
    state_d   = state_q;
    load_byte = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_pend && !tx_busy) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (mask_cur != 4'd0) begin
          state_d   = S_SEND;
          load_byte = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_SEND: begin
        state_d = S_GUARD;
      end
      S_GUARD: begin
        if (guard_cnt_q == 2'd0) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (mask_cur != 4'd0) begin
            state_d   = S_SEND;
            load_byte = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_write    = (state_q == S_SEND);
  assign tx_byte     = tx_byte_q;
  assign id_done     = (state_q == S_DONE) && (src_q == SRC_ID);
  assign meta_done   = (state_q == S_DONE) && (src_q == SRC_META);
  assign sample_done = (state_q == S_DONE) && (src_q == SRC_SAMPLE);
  assign xmit_idle   = (state_q == S_IDLE) && !any_pend && !tx_busy;
  assign overflow    = overflow_q;

  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      state_q     <= S_IDLE;
      src_q       <= SRC_ID;
      mask_q      <= 4'd0;
      tx_byte_q   <= 8'd0;
      guard_cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) src_q <= pick_src;
      if (load_byte) begin
        tx_byte_q <= byte_pick;
        mask_q    <= mask_cur & ~low_bit;
      end else if (state_q == S_GRANT) begin
        mask_q <= mask_sel;
      end
      if (state_q == S_SEND) begin
        guard_cnt_q <= GUARD_LOAD;
      end else if (state_q == S_GUARD && guard_cnt_q != 2'd0) begin
        guard_cnt_q <= guard_cnt_q - 2'd1;
      end
    end
  end

  // A request landing in its own DONE cycle is a fresh request: the clear wins
  assign overflow_hit = (id_req     && id_pend_q     && !id_done)
                      | (meta_req   && meta_pend_q   && !meta_done)
                      | (sample_req && sample_pend_q && !sample_done);

  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      id_pend_q     <= 1'b0;
      meta_pend_q   <= 1'b0;
      sample_pend_q <= 1'b0;
      meta_data_q   <= 8'd0;
      sample_data_q <= 32'd0;
      sample_mask_q <= 4'd0;
      overflow_q    <= 1'b0;
    end else begin
      id_pend_q     <= id_req     | (id_pend_q     & ~id_done);
      meta_pend_q   <= meta_req   | (meta_pend_q   & ~meta_done);
      sample_pend_q <= sample_req | (sample_pend_q & ~sample_done);
      if (meta_req && (!meta_pend_q || meta_done)) meta_data_q <= meta_data;
      if (sample_req && (!sample_pend_q || sample_done)) begin
        sample_data_q <= sample_data;
        sample_mask_q <= ~disabled_groups;
      end
      if (overflow_hit) overflow_q <= 1'b1;
    end
  end

`ifdef XMIT_ARB_ROUNDROBIN_EN
  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      last_meta_q <= 1'b0;
    end else if (state_q == S_GRANT) begin
      if (src_q == SRC_META) last_meta_q <= 1'b1;
      else if (src_q == SRC_SAMPLE) last_meta_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_xmit_arbiter.sv
// tb_xmit_arbiter: directed checks of xmit_arbiter against a busy-flag transmitter model.
module tb_xmit_arbiter;

  logic        clock = 1'b0;
  logic        extReset = 1'b1;
  logic        id_req = 1'b0, meta_req = 1'b0, sample_req = 1'b0;
  logic [7:0]  meta_data = 8'h00;
  logic [31:0] sample_data = 32'h0;
  logic [3:0]  disabled_groups = 4'h0;
  logic        tx_busy;
  logic        tx_write, id_done, meta_done, sample_done, xmit_idle, overflow;
  logic [7:0]  tx_byte;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int busy_left = 0, busy_viol = 0;
  int busy_len = 4;
  bit busy_force = 1'b0;
  logic [7:0] log_q[$];
  int         wcyc_q[$];
  int done_cnt[3];
  int done_cyc[3];

  xmit_arbiter dut (
    .clock(clock), .extReset(extReset),
    .id_req(id_req), .meta_req(meta_req), .meta_data(meta_data),
    .sample_req(sample_req), .sample_data(sample_data), .disabled_groups(disabled_groups),
    .tx_busy(tx_busy), .tx_write(tx_write), .tx_byte(tx_byte),
    .id_done(id_done), .meta_done(meta_done), .sample_done(sample_done),
    .xmit_idle(xmit_idle), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor plus transmitter model: busy for busy_len cycles from each strobe
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_write === 1'b1) begin
        log_q.push_back(tx_byte);
        wcyc_q.push_back(cyc);
        if (tx_busy) busy_viol++;
        busy_left = busy_len;
      end
      if (id_done === 1'b1)     begin done_cnt[0]++; done_cyc[0] = cyc; end
      if (meta_done === 1'b1)   begin done_cnt[1]++; done_cyc[1] = cyc; end
      if (sample_done === 1'b1) begin done_cnt[2]++; done_cyc[2] = cyc; end
      if (busy_force || busy_left > 0) begin
        tx_busy = 1'b1;
        if (busy_left > 0) busy_left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    log_q.delete();
    wcyc_q.delete();
    busy_viol = 0;
    for (int i = 0; i < 3; i++) begin done_cnt[i] = 0; done_cyc[i] = 0; end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
    #1;
  endtask

  task automatic wait_done(input int src, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (done_cnt[src] >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_meta(input logic [7:0] d, output int rc);
    @(negedge clock);
    rc = cyc; meta_req = 1'b1; meta_data = d;
    @(negedge clock);
    meta_req = 1'b0;
  endtask

  task automatic pulse_sample(input logic [31:0] d, input logic [3:0] dg, output int rc);
    @(negedge clock);
    rc = cyc; sample_req = 1'b1; sample_data = d; disabled_groups = dg;
    @(negedge clock);
    sample_req = 1'b0;
  endtask

  task automatic pulse_id(output int rc);
    @(negedge clock);
    rc = cyc; id_req = 1'b1;
    @(negedge clock);
    id_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    extReset = 1'b1;
    idle_cycles(2);
    @(negedge clock);
    extReset = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_reset();
    extReset = 1'b1;
    idle_cycles(3);
    n_cmp++; if (tx_write !== 1'b0) begin n_bad++; $display("FAIL reset_tx_write: got %b want 0", tx_write); end
    n_cmp++; if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
    n_cmp++; if ({id_done, meta_done, sample_done} !== 3'b000) begin
      n_bad++; $display("FAIL reset_done: got %b want 000", {id_done, meta_done, sample_done}); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (xmit_idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", xmit_idle); end
    @(negedge clock);
    extReset = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_single_meta();
    int rc; bit ok;
    clear_logs();
    pulse_meta(8'h40, rc);
    wait_done(1, 1, 60, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL meta_timeout: got no meta_done want one"); end
    n_cmp++; if (log_q.size() !== 1) begin n_bad++; $display("FAIL meta_count: got %0d want 1", log_q.size()); end
    n_cmp++; if ((log_q.size() > 0 ? log_q[0] : 8'hxx) !== 8'h40) begin
      n_bad++; $display("FAIL meta_byte: got %h want 40", log_q.size() > 0 ? log_q[0] : 8'hxx); end
    n_cmp++; if ((wcyc_q.size() > 0 ? wcyc_q[0] - rc : -1) !== 3) begin
      n_bad++; $display("FAIL meta_latency: got %0d want 3", wcyc_q.size() > 0 ? wcyc_q[0] - rc : -1); end
    n_cmp++; if ((wcyc_q.size() > 0 ? done_cyc[1] - wcyc_q[0] : -1) !== 5) begin
      n_bad++; $display("FAIL meta_done_time: got %0d want 5", wcyc_q.size() > 0 ? done_cyc[1] - wcyc_q[0] : -1); end
    idle_cycles(1);
    n_cmp++; if (xmit_idle !== 1'b1) begin n_bad++; $display("FAIL meta_idle_after: got %b want 1", xmit_idle); end
  endtask

  task automatic test_id_word();
    int rc; bit ok;
    logic [7:0] exp_b[4];
    logic [7:0] got;
    exp_b = '{8'h31, 8'h41, 8'h4C, 8'h53};
    clear_logs();
    pulse_id(rc);
    wait_done(0, 1, 100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL id_timeout: got no id_done want one"); end
    n_cmp++; if (log_q.size() !== 4) begin n_bad++; $display("FAIL id_count: got %0d want 4", log_q.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < log_q.size()) ? log_q[k] : 8'hxx;
      n_cmp++; if (got !== exp_b[k]) begin n_bad++; $display("FAIL id_byte%0d: got %h want %h", k, got, exp_b[k]); end
    end
    n_cmp++; if (busy_viol !== 0) begin n_bad++; $display("FAIL id_paced: got %0d strobes while busy want 0", busy_viol); end
    n_cmp++; if ((wcyc_q.size() > 3 ? wcyc_q[3] - wcyc_q[2] : -1) !== 5) begin
      n_bad++; $display("FAIL id_spacing: got %0d want 5", wcyc_q.size() > 3 ? wcyc_q[3] - wcyc_q[2] : -1); end
    idle_cycles(3);
    n_cmp++; if (done_cnt[0] !== 1) begin n_bad++; $display("FAIL id_done_count: got %0d want 1", done_cnt[0]); end
  endtask

  task automatic test_sample_mask();
    int rc; bit ok;
    logic [7:0] got;
    clear_logs();
    pulse_sample(32'hDDCCBBAA, 4'b0101, rc);
    wait_done(2, 1, 80, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mask_timeout: got no sample_done want one"); end
    n_cmp++; if (log_q.size() !== 2) begin n_bad++; $display("FAIL mask_count: got %0d want 2", log_q.size()); end
    got = (log_q.size() > 0) ? log_q[0] : 8'hxx;
    n_cmp++; if (got !== 8'hBB) begin n_bad++; $display("FAIL mask_byte0: got %h want BB", got); end
    got = (log_q.size() > 1) ? log_q[1] : 8'hxx;
    n_cmp++; if (got !== 8'hDD) begin n_bad++; $display("FAIL mask_byte1: got %h want DD", got); end
    idle_cycles(3);
    clear_logs();
    pulse_sample(32'h12345678, 4'b1111, rc);
    wait_done(2, 1, 20, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL skip_timeout: got no sample_done want one"); end
    n_cmp++; if (log_q.size() !== 0) begin n_bad++; $display("FAIL skip_no_write: got %0d strobes want 0", log_q.size()); end
    n_cmp++; if (done_cyc[2] - rc !== 3) begin
      n_bad++; $display("FAIL skip_done_time: got %0d want 3 after request", done_cyc[2] - rc); end
    idle_cycles(2);
  endtask

  task automatic test_collision();
    int rc, rm; bit ok, seen;
    logic [7:0] exp_b[5];
    logic [7:0] got;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5};
    clear_logs();
    pulse_sample(32'h44332211, 4'b0000, rc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock); #1;
      if (log_q.size() >= 1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL coll_first_strobe: got none want one"); end
    pulse_meta(8'hA5, rm);
    wait_done(1, 1, 120, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL coll_timeout: got no meta_done want one"); end
    for (int k = 0; k < 5; k++) begin
      got = (k < log_q.size()) ? log_q[k] : 8'hxx;
      n_cmp++; if (got !== exp_b[k]) begin n_bad++; $display("FAIL coll_byte%0d: got %h want %h", k, got, exp_b[k]); end
    end
    n_cmp++; if (done_cnt[2] !== 1) begin n_bad++; $display("FAIL coll_sample_done: got %0d want 1", done_cnt[2]); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL coll_overflow: got %b want 0", overflow); end
    idle_cycles(2);
  endtask

  task automatic test_tie_order();
    bit ok, hit;
    logic [7:0] exp_b[3];
    logic [7:0] got;
`ifdef XMIT_ARB_ROUNDROBIN_EN
    exp_b = '{8'h61, 8'h71, 8'h62};
`else
    exp_b = '{8'h61, 8'h62, 8'h71};
`endif
    do_reset();
    clear_logs();
    @(negedge clock);
    meta_req = 1'b1; meta_data = 8'h61;
    sample_req = 1'b1; sample_data = 32'h00000071; disabled_groups = 4'b1110;
    @(negedge clock);
    meta_req = 1'b0; sample_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clock);
      if (meta_done === 1'b1) begin
        meta_req = 1'b1; meta_data = 8'h62; hit = 1'b1;
      end
    end
    @(negedge clock);
    meta_req = 1'b0;
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL tie_first_done: got none want meta_done"); end
    wait_done(1, 2, 80, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tie_meta_timeout: got %0d meta_done want 2", done_cnt[1]); end
    wait_done(2, 1, 80, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tie_sample_timeout: got no sample_done want one"); end
    for (int k = 0; k < 3; k++) begin
      got = (k < log_q.size()) ? log_q[k] : 8'hxx;
      n_cmp++; if (got !== exp_b[k]) begin n_bad++; $display("FAIL tie_byte%0d: got %h want %h", k, got, exp_b[k]); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL tie_clear_wins: got overflow %b want 0", overflow); end
    idle_cycles(2);
  endtask

  task automatic test_overflow();
    int rc; bit ok;
    logic [7:0] got;
    clear_logs();
    busy_force = 1'b1;
    idle_cycles(2);
    pulse_meta(8'h01, rc);
    pulse_meta(8'h02, rc);
    idle_cycles(2);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_cmp++; if (log_q.size() !== 0) begin n_bad++; $display("FAIL ovf_held_by_busy: got %0d strobes want 0", log_q.size()); end
    n_cmp++; if (xmit_idle !== 1'b0) begin n_bad++; $display("FAIL ovf_not_idle: got %b want 0", xmit_idle); end
    busy_force = 1'b0;
    wait_done(1, 1, 60, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ovf_timeout: got no meta_done want one"); end
    idle_cycles(6);
    n_cmp++; if (log_q.size() !== 1) begin n_bad++; $display("FAIL ovf_count: got %0d want 1", log_q.size()); end
    got = (log_q.size() > 0) ? log_q[0] : 8'hxx;
    n_cmp++; if (got !== 8'h01) begin n_bad++; $display("FAIL ovf_kept_data: got %h want 01", got); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    @(negedge clock);
    extReset = 1'b1;
    #1;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_reset_clear: got %b want 0", overflow); end
    @(negedge clock);
    extReset = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_word();
    int rc; bit hit;
    clear_logs();
    pulse_id(rc);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clock); #1;
      if (log_q.size() >= 3 && tx_write === 1'b1) hit = 1'b1;
    end
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL rmw_third_strobe: got none want strobe"); end
    extReset = 1'b1;
    #1;
    n_cmp++; if (tx_write !== 1'b0) begin n_bad++; $display("FAIL rmw_write_drop: got %b want 0", tx_write); end
    n_cmp++; if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL rmw_byte_clear: got %h want 00", tx_byte); end
    idle_cycles(3);
    @(negedge clock);
    extReset = 1'b0;
    idle_cycles(12);
    n_cmp++; if (done_cnt[0] !== 0) begin n_bad++; $display("FAIL rmw_no_done: got %0d id_done want 0", done_cnt[0]); end
    n_cmp++; if (log_q.size() !== 3) begin n_bad++; $display("FAIL rmw_no_more: got %0d strobes want 3", log_q.size()); end
    n_cmp++; if (xmit_idle !== 1'b1) begin n_bad++; $display("FAIL rmw_idle: got %b want 1", xmit_idle); end
  endtask

  initial begin
    test_reset();
    test_single_meta();
    test_id_word();
    test_sample_mask();
    test_collision();
    test_tie_order();
    test_overflow();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
